// File: rtl/dualrail_pkg.sv
// -----------------------------------------------------------------------------
// dualrail_pkg
// Shared definitions for the dual-rail four-phase receiver:
//   - rx_state_t     : handshake FSM states
//   - SYNC_STAGES    : depth of the per-rail synchronizer
//   - e_active_level : maps the ENABLE_ACTIVE_HIGH parameter to the level
//                      of the enable output that means "ready for a token"
// -----------------------------------------------------------------------------
package dualrail_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_NEUTRAL = 2'd1,
        STALL        = 2'd2
    } rx_state_t;

    function automatic logic e_active_level(input int active_high);
        return (active_high != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/dualrail_sync2.sv
// -----------------------------------------------------------------------------
// dualrail_sync2
// Multi-flop synchronizer for one asynchronous rail (SYNC_STAGES flops).
// Ports:
//   clk   : sampling clock
//   reset : synchronous active-high reset, clears the chain to 0
//   d     : asynchronous input rail
//   q     : synchronized rail
// -----------------------------------------------------------------------------
module dualrail_sync2
    import dualrail_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_p0 <= '0;
        end else begin
            chain_p0 <= {chain_p0[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_p0[SYNC_STAGES-1];

endmodule

// File: rtl/dualrail_rx_deser.sv
// -----------------------------------------------------------------------------
// dualrail_rx_deser
// Clocked receiver for a 1-of-2 dual-rail four-phase channel. The rails are
// synchronized, each token is acknowledged through the enable output, WIDTH
// tokens are collected LSB-first into a word and the word is offered on a
// valid/ready stream.
//
// Parameters:
//   WIDTH              : bits per output word (>= 1)
//   ENABLE_ACTIVE_HIGH : 1 -> e high means "accepting"; 0 -> e low means it
// Ports:
//   clk       : sole clock, rising edge
//   reset     : synchronous active-high reset
//   d0, d1    : false / true rail (asynchronous)
//   e         : registered channel enable / acknowledge
//   out_data  : assembled word, bit 0 = first token
//   out_valid : out_data holds a word
//   out_ready : consumer accepts the word
//   error     : sticky flag for both rails high while waiting for a token;
//               present only when DUALRAIL_RX_ERROR_EN is defined
// Build option:
//   DUALRAIL_RX_ERROR_EN : adds the error port and illegal-code detection.
// -----------------------------------------------------------------------------
module dualrail_rx_deser
    import dualrail_pkg::*;
#(
    parameter int WIDTH              = 4,
    parameter int ENABLE_ACTIVE_HIGH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d0,
    input  logic             d1,
    output logic             e,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DUALRAIL_RX_ERROR_EN
    ,
    output logic             error
`endif
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(WIDTH);
    localparam logic             E_ACT  = e_active_level(ENABLE_ACTIVE_HIGH);
    localparam logic             E_INACT = ~E_ACT;

    logic             s0;
    logic             s1;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic             xfer;

    // Rail synchronizers: the FSM sees only s0/s1.
    dualrail_sync2 u_sync_d0 (
        .clk   (clk),
        .reset (reset),
        .d     (d0),
        .q     (s0)
    );

    dualrail_sync2 u_sync_d1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (s1)
    );

    // A full word moves to the output register whenever that register is
    // empty or is being emptied on this same edge, so accept and refill
    // happen back to back without a bubble.
    assign xfer = (cnt == FULL) && (!out_valid || out_ready);

    // Handshake FSM, shift register and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            e         <= E_INACT;
        end else begin
            if (xfer) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
                cnt       <= '0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Also the path that raises e on the first cycle out of reset.
                    e <= E_ACT;
                    // IDLE is only entered with room in the shift register,
                    // so a capture here can never collide with a transfer.
                    // Both rails high is captured as a 1 (s1).
                    if (s0 || s1) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                shreg[i] <= s1;
                            end
                        end
                        cnt   <= cnt + CNT_W'(1);
                        e     <= E_INACT;
                        state <= WAIT_NEUTRAL;
                    end
                end

                WAIT_NEUTRAL: begin
                    e <= E_INACT;
                    if (!s0 && !s1) begin
                        if ((cnt != FULL) || xfer) begin
                            e     <= E_ACT;
                            state <= IDLE;
                        end else begin
                            state <= STALL;
                        end
                    end
                end

                STALL: begin
                    // Holding e inactive is what pushes backpressure onto
                    // the asynchronous sender.
                    e <= E_INACT;
                    if (xfer) begin
                        e     <= E_ACT;
                        state <= IDLE;
                    end
                end

                default: begin
                    e     <= E_INACT;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DUALRAIL_RX_ERROR_EN
    // Both rails high is not a legal 1-of-2 code; remember it until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            error <= 1'b0;
        end else if ((state == IDLE) && s0 && s1) begin
            error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dualrail_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_dualrail_rx_deser
// Drives two receivers (active-high and active-low enable) with the same
// dual-rail sender and checks words against a token-level reference model.
// -----------------------------------------------------------------------------
module tb_dualrail_rx_deser;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             d0;
    logic             d1;
    logic             out_ready;
    logic             e_a;
    logic             e_b;
    logic             ov_a;
    logic             ov_b;
    logic [WIDTH-1:0] od_a;
    logic [WIDTH-1:0] od_b;
`ifdef DUALRAIL_RX_ERROR_EN
    logic             err_a;
    logic             err_b;
`endif

    dualrail_rx_deser #(.WIDTH(WIDTH), .ENABLE_ACTIVE_HIGH(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .d0        (d0),
        .d1        (d1),
        .e         (e_a),
        .out_data  (od_a),
        .out_valid (ov_a),
        .out_ready (out_ready)
`ifdef DUALRAIL_RX_ERROR_EN
        ,
        .error     (err_a)
`endif
    );

    dualrail_rx_deser #(.WIDTH(WIDTH), .ENABLE_ACTIVE_HIGH(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .d0        (d0),
        .d1        (d1),
        .e         (e_b),
        .out_data  (od_b),
        .out_valid (ov_b),
        .out_ready (out_ready)
`ifdef DUALRAIL_RX_ERROR_EN
        ,
        .error     (err_b)
`endif
    );

    // Token sequence written in send order, left (MSB) token first.
    typedef struct packed {
        logic [3:0] seq;
        logic [3:0] expw;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;

    // Reference model: tokens accumulate LSB-first; every WIDTH tokens form
    // one expected word per receiver.
    logic [WIDTH-1:0] acc = '0;
    int               mn  = 0;
    logic [WIDTH-1:0] q_a [$];
    logic [WIDTH-1:0] q_b [$];

    logic             rand_mode = 1'b0;
    logic             e_prev    = 1'b0;
    int               tog_a     = 0;
    int               vcyc_a    = 0;
    int               wc_a      = 0;
    int               wc_b      = 0;
    logic [WIDTH-1:0] last_a    = '0;
    logic [WIDTH-1:0] last_b    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        acc = {b, acc[WIDTH-1:1]};
        mn++;
        if (mn == WIDTH) begin
            q_a.push_back(acc);
            q_b.push_back(acc);
            mn = 0;
        end
    endtask

    // One clock: output monitor on the falling edge, then input update just
    // after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (e_a !== e_prev) tog_a++;
        e_prev = e_a;
        if (!reset) begin
            if (ov_a) begin
                vcyc_a++;
                checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL out_word_a unexpected actual=%0h required=none", od_a);
                end else begin
                    if (od_a !== q_a[0]) begin
                        failures++;
                        $display("FAIL out_data_a actual=%0h required=%0h", od_a, q_a[0]);
                    end
                    if (out_ready) begin
                        last_a = od_a;
                        wc_a++;
                        void'(q_a.pop_front());
                    end
                end
            end
            if (ov_b) begin
                checks++;
                if (q_b.size() == 0) begin
                    failures++;
                    $display("FAIL out_word_b unexpected actual=%0h required=none", od_b);
                end else begin
                    if (od_b !== q_b[0]) begin
                        failures++;
                        $display("FAIL out_data_b actual=%0h required=%0h", od_b, q_b[0]);
                    end
                    if (out_ready) begin
                        last_b = od_b;
                        wc_b++;
                        void'(q_b.pop_front());
                    end
                end
            end
        end
        @(posedge clk);
        #2;
        if (rand_mode) out_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic wait_e(input logic lvl, input string name);
        int n;
        n = 0;
        while (e_a !== lvl && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (e_a !== lvl) begin
            failures++;
            $display("FAIL %s timeout e_a=%b required=%b", name, e_a, lvl);
        end
    endtask

    task automatic send_token(input logic b, input logic both);
        wait_e(1'b1, "wait_e_active");
        d0 = both | ~b;
        d1 = both | b;
        push_bit(both | b);
        wait_e(1'b0, "wait_e_inactive");
        d0 = 1'b0;
        d1 = 1'b0;
        if (rand_mode) repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic reset_pulse(input int cyc);
        reset = 1'b1;
        d0    = 1'b0;
        d1    = 1'b0;
        q_a.delete();
        q_b.delete();
        mn  = 0;
        acc = '0;
        repeat (cyc) tick();
        reset = 1'b0;
    endtask

    initial begin
        int t0;
        int v0;
        int w0;
        logic bv;
        logic bb;

        vecs[0] = '{seq: 4'b0110, expw: 4'h6};
        vecs[1] = '{seq: 4'b1100, expw: 4'h3};
        vecs[2] = '{seq: 4'b1000, expw: 4'h1};
        vecs[3] = '{seq: 4'b1111, expw: 4'hF};
        vecs[4] = '{seq: 4'b0001, expw: 4'h8};
        vecs[5] = '{seq: 4'b1010, expw: 4'h5};
        vecs[6] = '{seq: 4'b0111, expw: 4'hE};

        reset     = 1'b1;
        d0        = 1'b0;
        d1        = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        // Reset state of both polarities.
        chk("reset_e_a", e_a, 1'b0);
        chk("reset_e_b", e_b, 1'b1);
        chk("reset_valid_a", ov_a, 1'b0);
        chk("reset_data_a", od_a, 4'h0);
        chk("reset_valid_b", ov_b, 1'b0);
        chk("reset_data_b", od_b, 4'h0);
`ifdef DUALRAIL_RX_ERROR_EN
        chk("reset_error_a", err_a, 1'b0);
`endif
        reset = 1'b0;
        tick();
        chk("release_e_a", e_a, 1'b1);
        chk("release_e_b", e_b, 1'b0);
        repeat (3) tick();

        // Table of words with the consumer always ready.
        for (int i = 0; i < NV; i++) begin
            t0 = tog_a;
            v0 = vcyc_a;
            for (int j = WIDTH - 1; j >= 0; j--) send_token(vecs[i].seq[j], 1'b0);
            wait_e(1'b1, "vec_done");
            repeat (3) tick();
            chk($sformatf("vec%0d_word_a", i), last_a, vecs[i].expw);
            chk($sformatf("vec%0d_word_b", i), last_b, vecs[i].expw);
            chk($sformatf("vec%0d_e_toggles", i), tog_a - t0, 8);
            chk($sformatf("vec%0d_valid_cycles", i), vcyc_a - v0, 1);
        end

        // Backpressure: one word held, a second word stalls the channel.
        out_ready = 1'b0;
        send_token(1'b1, 1'b0);
        send_token(1'b0, 1'b0);
        send_token(1'b0, 1'b0);
        send_token(1'b0, 1'b0);
        for (int j = 0; j < 4; j++) send_token(1'b1, 1'b0);
        repeat (10) tick();
        chk("bp_e_a_held", e_a, 1'b0);
        chk("bp_e_b_held", e_b, 1'b1);
        chk("bp_valid_a", ov_a, 1'b1);
        chk("bp_data_a", od_a, 4'h1);
        chk("bp_data_b", od_b, 4'h1);

        // Accept and refill on the same edge.
        out_ready = 1'b1;
        tick();
        chk("sim_valid_a", ov_a, 1'b1);
        chk("sim_data_a", od_a, 4'hF);
        chk("sim_data_b", od_b, 4'hF);
        chk("sim_e_a_active", e_a, 1'b1);
        chk("sim_e_b_active", e_b, 1'b0);
        tick();
        chk("sim_valid_fall_a", ov_a, 1'b0);
        chk("bp_words_a", wc_a, NV + 2);

        // Reset in the middle of a word.
        send_token(1'b1, 1'b0);
        send_token(1'b0, 1'b0);
        tick();
        reset_pulse(1);
        chk("midrst_valid_a", ov_a, 1'b0);
        chk("midrst_valid_b", ov_b, 1'b0);
        chk("midrst_e_a", e_a, 1'b0);
        tick();
        chk("midrst_e_a_release", e_a, 1'b1);
        w0 = wc_a;
        send_token(1'b1, 1'b0);
        send_token(1'b1, 1'b0);
        send_token(1'b0, 1'b0);
        send_token(1'b0, 1'b0);
        wait_e(1'b1, "midrst_done");
        repeat (3) tick();
        chk("midrst_word_a", last_a, 4'h3);
        chk("midrst_count_a", wc_a - w0, 1);

        // Both rails high, with handshake latency checks.
        wait_e(1'b1, "ill_wait");
        d0 = 1'b1;
        d1 = 1'b1;
        push_bit(1'b1);
        tick();
        tick();
        chk("lat_e_still_active", e_a, 1'b1);
        tick();
        chk("lat_e_inactive", e_a, 1'b0);
`ifdef DUALRAIL_RX_ERROR_EN
        chk("ill_error_a", err_a, 1'b1);
        chk("ill_error_b", err_b, 1'b1);
`endif
        d0 = 1'b0;
        d1 = 1'b0;
        tick();
        tick();
        chk("lat_neutral_hold", e_a, 1'b0);
        tick();
        chk("lat_neutral_active", e_a, 1'b1);
        w0 = wc_a;
        send_token(1'b0, 1'b0);
        send_token(1'b1, 1'b0);
        send_token(1'b0, 1'b0);
        wait_e(1'b1, "ill_done");
        repeat (3) tick();
        chk("ill_word_a", last_a, 4'h5);
        chk("ill_count_a", wc_a - w0, 1);
`ifdef DUALRAIL_RX_ERROR_EN
        chk("ill_error_sticky", err_a, 1'b1);
`endif
        reset_pulse(2);
`ifdef DUALRAIL_RX_ERROR_EN
        chk("ill_error_cleared", err_a, 1'b0);
`endif
        repeat (3) tick();

        // Randomized tokens and consumer backpressure.
        rand_mode = 1'b1;
        for (int k = 0; k < 48; k++) begin
            bv = ($urandom_range(0, 1) == 1);
            bb = ($urandom_range(0, 7) == 0);
            send_token(bv, bb);
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        chk("rand_drain_a", q_a.size(), 0);
        chk("rand_drain_b", q_b.size(), 0);
        chk("rand_partial", mn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
